beam_delay_array: RTL
=====================

# beam_delay_array

Parametrised multi-channel fractional-free delay stage for the microphone beamformer. It accepts one PCM sample per channel per input strobe and stores a per-channel history in a shared circular buffer. Each channel's output is delayed by an integer number of samples taken from a programmable steering table indexed by `delay_select`. It also produces the registered delay-and-sum of all channels, and sits between the PDM-to-PCM decimators and the beam power/selection logic.

## Interface
- `NUM_CH`, 16, number of microphone channels
- `DATA_W`, 19, signed PCM sample width
- `MAX_DELAY`, 32, history depth in samples (power of two); legal delays 0..MAX_DELAY-1
- `DELAY_W`, $clog2(MAX_DELAY), delay field width
- `NUM_ANGLES`, 32, steering table entries
- `SEL_W`, $clog2(NUM_ANGLES), angle index width
- `SUM_W`, DATA_W+$clog2(NUM_CH), sum width
- `clk`  in  1  single clock; all logic on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `in_valid`  in  1  one new sample set present on `in_data`
- `in_data`  in  NUM_CH*DATA_W  packed signed samples, channel i at bits [i*DATA_W +: DATA_W]
- `delay_select`  in  SEL_W  steering angle index for the sample accepted this cycle
- `cfg_we`  in  1  steering table write strobe
- `cfg_angle`  in  SEL_W  table row to write
- `cfg_ch`  in  $clog2(NUM_CH)  table column to write
- `cfg_delay`  in  DELAY_W  delay value to write
- `out_valid`  out  1  `out_data` holds a new delayed sample set
- `out_data`  out  NUM_CH*DATA_W  packed delayed samples, same packing as `in_data`
- `sum_valid`  out  1  `sum_data` is valid
- `sum_data`  out  SUM_W  signed sum of the `out_data` channels

## Operation
- History buffer: NUM_CH x MAX_DELAY x DATA_W, with one write pointer `wr_ptr` (DELAY_W bits) shared by all channels.
- On `in_valid`, write each channel to `hist[i][wr_ptr]`, then increment `wr_ptr` modulo MAX_DELAY, wrapping from MAX_DELAY-1 to 0.
- Read per channel on the same `in_valid` cycle, with d = `table[delay_select][i]`:
  - d=0 returns the incoming `in_data` channel, bypassing the buffer.
  - d>0 returns `hist[i][(wr_ptr-d) mod MAX_DELAY]`, i.e. the sample accepted d strobes earlier.
- Fill counter `fill` counts accepted samples and saturates at MAX_DELAY-1. If d > `fill`, the channel outputs 0; stale or reset history is never emitted.
- All channels of one sample use the same `delay_select`, sampled on the `in_valid` cycle. Changing `delay_select` between strobes switches every channel together at the next sample, with no partial-angle output.
- Steering table: NUM_ANGLES x NUM_CH x DELAY_W registers. `cfg_we` writes `table[cfg_angle][cfg_ch] <= cfg_delay`. Writes are accepted on any cycle, independent of `in_valid`.
- If `cfg_we` and `in_valid` coincide on the entry being read, the read uses the old table value and the new value applies from the next strobe.
- Sum: full-precision signed sum of the NUM_CH `out_data` words, sign-extended to SUM_W. It can never overflow.
- Samples with no `in_valid` are not stored, and the pointer holds. Inter-strobe spacing is arbitrary, including back-to-back every cycle.

## Timing
- `out_data`/`out_valid` are registered and appear 1 cycle after the accepting `in_valid`. `out_valid` is a 1-cycle pulse per accepted sample.
- `sum_data`/`sum_valid` appear 2 cycles after `in_valid` (1 cycle after `out_valid`). `sum_valid` is a 1-cycle pulse.
- Throughput: one sample set per clock.
- `out_data` and `sum_data` hold their last value between valid pulses.
- Reset values:
  - `out_valid`=0, `out_data`=0, `sum_valid`=0, `sum_data`=0.
  - `wr_ptr`=0, `fill`=0, all table entries=0, history contents=0.
- Reset mid-stream: in-flight samples are discarded, with no valid pulse after reset asserts. The first post-reset sample sees `fill`=0, so any channel with d>0 outputs 0.
- A table write takes effect from the first `in_valid` strictly after the `cfg_we` cycle.

## Test plan
- Reset / defaults:
  - Stimulus: assert `rst` during traffic, release, feed ch0=5 with all delays 0.
  - Required: all outputs 0 during reset; `out_valid` 1 cycle after the strobe with ch0=5; `sum_data`=5 one cycle later.
- Impulse delay:
  - Stimulus: program angle 3 with ch i delay = i; feed an impulse of value 1000 on all channels followed by zeros, `delay_select`=3.
  - Required: channel i shows 1000 exactly i strobes after the impulse; `sum_data`=1000 on each of 16 consecutive sums.
- Fill guard and wrap:
  - Stimulus: delay 31 on ch0; feed a ramp 1,2,3,... for 70 strobes.
  - Required: ch0=0 for the first 31 outputs, then output k = k-31 (ramp value), continuing correctly across two `wr_ptr` wraps.
- Angle switch:
  - Stimulus: angles 0 and 1 hold different delays; toggle `delay_select` between strobes.
  - Required: each output set matches exactly one angle, with no mixed channels.
- Simultaneous config and read:
  - Stimulus: `cfg_we` on the active entry, changing its delay from 2 to 5, in the same cycle as `in_valid`.
  - Required: that sample uses delay 2; the next strobe uses delay 5.
- Sum extremes:
  - Stimulus: all 16 channels at -2^18 with delay 0.
  - Required: `sum_data` = -2^22, correct sign, no wrap; all channels at 2^18-1 gives 16*(2^18-1).

Source files
------------

// File: rtl/beam_delay_array_if.sv
// rtl/beam_delay_array_if.sv - sample, steering-config and output bundle for beam_delay_array
interface beam_delay_array_if #(
  parameter int NUM_CH     = 16,
  parameter int DATA_W     = 19,
  parameter int MAX_DELAY  = 32,
  parameter int NUM_ANGLES = 32
);
  localparam int DELAY_W = $clog2(MAX_DELAY);
  localparam int SEL_W   = $clog2(NUM_ANGLES);
  localparam int CH_W    = $clog2(NUM_CH);
  localparam int SUM_W   = DATA_W + $clog2(NUM_CH);

  logic                     in_valid;
  logic [NUM_CH*DATA_W-1:0] in_data;
  logic [SEL_W-1:0]         delay_select;
  logic                     cfg_we;
  logic [SEL_W-1:0]         cfg_angle;
  logic [CH_W-1:0]          cfg_ch;
  logic [DELAY_W-1:0]       cfg_delay;
  logic                     out_valid;
  logic [NUM_CH*DATA_W-1:0] out_data;
  logic                     sum_valid;
  logic [SUM_W-1:0]         sum_data;

  modport master (
    output in_valid, in_data, delay_select, cfg_we, cfg_angle, cfg_ch, cfg_delay,
    input  out_valid, out_data, sum_valid, sum_data
  );

  modport slave (
    input  in_valid, in_data, delay_select, cfg_we, cfg_angle, cfg_ch, cfg_delay,
    output out_valid, out_data, sum_valid, sum_data
  );
endinterface

// File: rtl/beam_delay_array.sv
// rtl/beam_delay_array.sv - per-channel integer delay line with steering table and delay-and-sum
module beam_delay_array #(
  parameter int NUM_CH     = 16,
  parameter int DATA_W     = 19,
  parameter int MAX_DELAY  = 32,
  parameter int DELAY_W    = $clog2(MAX_DELAY),
  parameter int NUM_ANGLES = 32,
  parameter int SEL_W      = $clog2(NUM_ANGLES),
  parameter int SUM_W      = DATA_W + $clog2(NUM_CH)
) (
  input  logic               clk,
  input  logic               rst,
  beam_delay_array_if.slave  bus
);
  localparam logic [DELAY_W-1:0] FILL_MAX = DELAY_W'(MAX_DELAY - 1);

  logic [DATA_W-1:0]        hist [NUM_CH][MAX_DELAY];
  logic [DELAY_W-1:0]       tbl  [NUM_ANGLES][NUM_CH];
  logic [DELAY_W-1:0]       wr_ptr;
  logic [DELAY_W-1:0]       fill;
  logic [DELAY_W-1:0]       cur_d [NUM_CH];
  logic [NUM_CH*DATA_W-1:0] rd_data;
  logic signed [SUM_W-1:0]  sum_next;

  // Delays beyond the number of samples seen so far read as silence, never stale history.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      cur_d[i] = tbl[bus.delay_select][i];
      if (cur_d[i] == '0)
        rd_data[i*DATA_W +: DATA_W] = bus.in_data[i*DATA_W +: DATA_W];
      else if (cur_d[i] <= fill)
        rd_data[i*DATA_W +: DATA_W] = hist[i][wr_ptr - cur_d[i]];
    end
  end

  always_comb begin
    sum_next = '0;
    for (int i = 0; i < NUM_CH; i++)
      sum_next = sum_next + SUM_W'($signed(bus.out_data[i*DATA_W +: DATA_W]));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int a = 0; a < NUM_ANGLES; a++)
        for (int i = 0; i < NUM_CH; i++)
          tbl[a][i] <= '0;
    end else if (bus.cfg_we) begin
      tbl[bus.cfg_angle][bus.cfg_ch] <= bus.cfg_delay;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++)
        for (int k = 0; k < MAX_DELAY; k++)
          hist[i][k] <= '0;
    end else if (bus.in_valid) begin
      for (int i = 0; i < NUM_CH; i++)
        hist[i][wr_ptr] <= bus.in_data[i*DATA_W +: DATA_W];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      fill   <= '0;
    end else if (bus.in_valid) begin
      wr_ptr <= wr_ptr + 1'b1;
      if (fill != FILL_MAX)
        fill <= fill + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.out_valid <= 1'b0;
      bus.out_data  <= '0;
      bus.sum_valid <= 1'b0;
      bus.sum_data  <= '0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid)
        bus.out_data <= rd_data;
      bus.sum_valid <= bus.out_valid;
      if (bus.out_valid)
        bus.sum_data <= $unsigned(sum_next);
    end
  end
endmodule
